control_sequencer: RTL and testbench

- Microcode step sequencer and control-word decoder for the 8-bit computer.
- Consumes the computer clock `c_clk` produced by the clock block and sends `HLT` back to it.
- Runs entirely in the `sys_clk` domain: samples `c_clk`, advances a T-state counter on each `c_clk` falling edge, and decodes opcode, step and flags into a 16-bit control word.
- Sits between the instruction register/flags register and all bus-attached modules.

---
 rtl/control_sequencer.sv | 116 +++++++++++
 tb/tb_control_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Microcode T-state sequencer and control-word decoder; steps advance on c_clk falling edges seen in the sys_clk domain.
// Step/step_strobe update 2 sys_clk after a c_clk fall, ctrl_word decodes combinationally; no backpressure, halts on HLT.
module control_sequencer #(
    parameter int EARLY_END = 1,
    parameter int NUM_STEPS = 5
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        c_clk,
    input  logic [3:0]  opcode,
    input  logic        flag_c,
    input  logic        flag_z,
    output logic [15:0] ctrl_word,
    output logic        hlt,
    output logic [2:0]  t_state,
    output logic        step_strobe
);

    localparam logic [15:0] C_HLT = 16'h8000;
    localparam logic [15:0] C_MI  = 16'h4000;
    localparam logic [15:0] C_RI  = 16'h2000;
    localparam logic [15:0] C_RO  = 16'h1000;
    localparam logic [15:0] C_IO  = 16'h0800;
    localparam logic [15:0] C_II  = 16'h0400;
    localparam logic [15:0] C_AI  = 16'h0200;
    localparam logic [15:0] C_AO  = 16'h0100;
    localparam logic [15:0] C_EO  = 16'h0080;
    localparam logic [15:0] C_SU  = 16'h0040;
    localparam logic [15:0] C_BI  = 16'h0020;
    localparam logic [15:0] C_OI  = 16'h0010;
    localparam logic [15:0] C_CE  = 16'h0008;
    localparam logic [15:0] C_CO  = 16'h0004;
    localparam logic [15:0] C_J   = 16'h0002;
    localparam logic [15:0] C_FI  = 16'h0001;

    localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);

    logic        s1, s2;
    logic        fall;
    logic [2:0]  step, step_nxt;
    logic [15:0] next_word;

    // Step index is 4 bits wide so step+1 never wraps back onto T0.
    function automatic logic [15:0] decode(input logic [3:0] st, input logic [3:0] op,
                                           input logic fc, input logic fz);
        logic [15:0] w;
        w = '0;
        case (st)
            4'd0: w = C_CO | C_MI;
            4'd1: w = C_RO | C_II | C_CE;
            4'd2: begin
                case (op)
                    4'h1, 4'h2, 4'h3, 4'h4: w = C_IO | C_MI;
                    4'h5: w = C_IO | C_AI;
                    4'h6: w = C_IO | C_J;
                    4'h7: w = fc ? (C_IO | C_J) : 16'h0000;
                    4'h8: w = fz ? (C_IO | C_J) : 16'h0000;
                    4'hE: w = C_AO | C_OI;
                    4'hF: w = C_HLT;
                    default: w = '0;
                endcase
            end
            4'd3: begin
                case (op)
                    4'h1: w = C_RO | C_AI;
                    4'h2, 4'h3: w = C_RO | C_BI;
                    4'h4: w = C_AO | C_RI;
                    default: w = '0;
                endcase
            end
            4'd4: begin
                case (op)
                    4'h2: w = C_EO | C_AI | C_FI;
                    4'h3: w = C_EO | C_AI | C_SU | C_FI;
                    default: w = '0;
                endcase
            end
            default: w = '0;
        endcase
        return w;
    endfunction

    assign fall      = s2 & ~s1;
    assign ctrl_word = decode({1'b0, step}, opcode, flag_c, flag_z);
    assign next_word = decode({1'b0, step} + 4'd1, opcode, flag_c, flag_z);
    assign hlt       = ctrl_word[15];
    assign t_state   = step;

    always_comb begin
        step_nxt = step;
        if (fall && !ctrl_word[15]) begin
            if (step == LAST_STEP) begin
                step_nxt = 3'd0;
            end else if ((EARLY_END != 0) && (step >= 3'd1) && (next_word == 16'h0000)) begin
                step_nxt = 3'd0;
            end else begin
                step_nxt = step + 3'd1;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            step        <= 3'd0;
            step_strobe <= 1'b0;
        end else begin
            s1          <= c_clk;
            s2          <= s1;
            step        <= step_nxt;
            step_strobe <= (step_nxt != step);
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed and randomized checks of control_sequencer (EARLY_END=1 and EARLY_END=0 instances) against a microprogram-table model.
module tb_control_sequencer;

    localparam logic [15:0] B_HLT = 16'h8000, B_MI = 16'h4000, B_RI = 16'h2000, B_RO = 16'h1000;
    localparam logic [15:0] B_IO  = 16'h0800, B_II = 16'h0400, B_AI = 16'h0200, B_AO = 16'h0100;
    localparam logic [15:0] B_EO  = 16'h0080, B_SU = 16'h0040, B_BI = 16'h0020, B_OI = 16'h0010;
    localparam logic [15:0] B_CE  = 16'h0008, B_CO = 16'h0004, B_J  = 16'h0002, B_FI = 16'h0001;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        c_clk;
    logic [3:0]  opcode;
    logic        flag_c, flag_z;
    logic [15:0] cw1, cw0;
    logic        hlt1, hlt0, sb1, sb0;
    logic [2:0]  ts1, ts0;

    int vectors = 0;
    int miscompares = 0;
    int m1 = 0;
    int m0 = 0;
    logic [15:0] prog [16][5];

    always #5 sys_clk = ~sys_clk;

    control_sequencer #(.EARLY_END(1), .NUM_STEPS(5)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .c_clk(c_clk), .opcode(opcode),
        .flag_c(flag_c), .flag_z(flag_z), .ctrl_word(cw1), .hlt(hlt1),
        .t_state(ts1), .step_strobe(sb1)
    );

    control_sequencer #(.EARLY_END(0), .NUM_STEPS(5)) dut0 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .c_clk(c_clk), .opcode(opcode),
        .flag_c(flag_c), .flag_z(flag_z), .ctrl_word(cw0), .hlt(hlt0),
        .t_state(ts0), .step_strobe(sb0)
    );

    function automatic logic [15:0] word(input int op, input int s, input logic fc, input logic fz);
        if (s > 4) return 16'h0000;
        if (s == 2 && ((op == 7 && !fc) || (op == 8 && !fz))) return 16'h0000;
        return prog[op][s];
    endfunction

    // An instruction is as long as its program up to the last non-zero word (never shorter than T0,T1).
    function automatic int next_step(input int op, input int s, input logic fc, input logic fz, input bit ee);
        logic [15:0] w;
        int len;
        w = word(op, s, fc, fz);
        if (w[15]) return s;
        len = 5;
        if (ee) begin
            len = 2;
            for (int i = 2; i < 5; i++)
                if (word(op, i, fc, fz) != 16'h0000) len = i + 1;
        end
        return (s + 1 >= len) ? 0 : s + 1;
    endfunction

    function automatic bit halted(input int s);
        logic [15:0] w;
        w = word(opcode, s, flag_c, flag_z);
        return w[15];
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [15:0] w1, w0;
        w1 = word(opcode, m1, flag_c, flag_z);
        w0 = word(opcode, m0, flag_c, flag_z);
        chk({tag, " t_state"}, {13'b0, ts1}, 16'(m1));
        chk({tag, " ctrl_word"}, cw1, w1);
        chk({tag, " hlt"}, {15'b0, hlt1}, {15'b0, w1[15]});
        chk({tag, " t_state0"}, {13'b0, ts0}, 16'(m0));
        chk({tag, " ctrl_word0"}, cw0, w0);
        chk({tag, " hlt0"}, {15'b0, hlt0}, {15'b0, w0[15]});
    endtask

    task automatic chk_no_strobe(input string tag);
        chk({tag, " strobe"}, {15'b0, sb1}, 16'h0000);
        chk({tag, " strobe0"}, {15'b0, sb0}, 16'h0000);
    endtask

    task automatic do_fall(input string tag);
        int n1, n0;
        @(negedge sys_clk) c_clk = 1'b1;
        repeat (3) @(negedge sys_clk);
        c_clk = 1'b0;
        n1 = next_step(opcode, m1, flag_c, flag_z, 1'b1);
        n0 = next_step(opcode, m0, flag_c, flag_z, 1'b0);
        @(negedge sys_clk);
        chk({tag, " early t_state"}, {13'b0, ts1}, 16'(m1));
        chk({tag, " early t_state0"}, {13'b0, ts0}, 16'(m0));
        chk_no_strobe({tag, " early"});
        @(negedge sys_clk);
        chk({tag, " strobe"}, {15'b0, sb1}, {15'b0, (n1 != m1)});
        chk({tag, " strobe0"}, {15'b0, sb0}, {15'b0, (n0 != m0)});
        m1 = n1;
        m0 = n0;
        check_all(tag);
        @(negedge sys_clk);
        chk_no_strobe({tag, " after"});
    endtask

    task automatic apply_reset(input string tag);
        @(negedge sys_clk) sys_rst = 1'b1;
        m1 = 0;
        m0 = 0;
        @(negedge sys_clk);
        check_all(tag);
        chk_no_strobe(tag);
        sys_rst = 1'b0;
    endtask

    initial begin
        logic [15:0] add_seq [5];
        logic [15:0] nop_seq [5];
        add_seq = '{16'h1408, 16'h4800, 16'h1020, 16'h0281, 16'h4004};
        nop_seq = '{16'h1408, 16'h0000, 16'h0000, 16'h0000, 16'h4004};

        for (int op = 0; op < 16; op++) begin
            prog[op][0] = B_CO | B_MI;
            prog[op][1] = B_RO | B_II | B_CE;
            for (int s = 2; s < 5; s++) prog[op][s] = 16'h0000;
        end
        prog[1][2] = B_IO | B_MI;  prog[1][3] = B_RO | B_AI;
        prog[2][2] = B_IO | B_MI;  prog[2][3] = B_RO | B_BI;  prog[2][4] = B_EO | B_AI | B_FI;
        prog[3][2] = B_IO | B_MI;  prog[3][3] = B_RO | B_BI;  prog[3][4] = B_EO | B_AI | B_SU | B_FI;
        prog[4][2] = B_IO | B_MI;  prog[4][3] = B_AO | B_RI;
        prog[5][2] = B_IO | B_AI;
        prog[6][2] = B_IO | B_J;
        prog[7][2] = B_IO | B_J;
        prog[8][2] = B_IO | B_J;
        prog[14][2] = B_AO | B_OI;
        prog[15][2] = B_HLT;

        // Reset with c_clk high, then hold it high.
        sys_rst = 1'b1; c_clk = 1'b1; opcode = 4'h0; flag_c = 1'b0; flag_z = 1'b0;
        #1;
        check_all("in_reset");
        chk("in_reset ctrl const", cw1, 16'h4004);
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            check_all("idle_high");
            chk_no_strobe("idle_high");
        end

        // ADD with early end: full five-step sequence.
        opcode = 4'h2;
        for (int i = 0; i < 5; i++) begin
            do_fall("add");
            chk("add const", cw1, add_seq[i]);
        end

        // JC with carry clear then set.
        apply_reset("rst_jc");
        opcode = 4'h7; flag_c = 1'b0;
        do_fall("jc0"); do_fall("jc0");
        chk("jc0 back to t0", {13'b0, ts1}, 16'h0000);
        flag_c = 1'b1;
        do_fall("jc1"); do_fall("jc1");
        chk("jc1 t2 word", cw1, 16'h0802);
        do_fall("jc1");
        chk("jc1 back to t0", {13'b0, ts1}, 16'h0000);

        // NOP without early end walks all five steps.
        apply_reset("rst_nop");
        opcode = 4'h0; flag_c = 1'b0;
        for (int i = 0; i < 5; i++) begin
            do_fall("nop");
            chk("nop ee0 const", cw0, nop_seq[i]);
        end

        // HLT freezes until reset.
        apply_reset("rst_hlt");
        opcode = 4'hF;
        for (int i = 0; i < 3; i++) do_fall("hlt");
        chk("hlt word", cw1, 16'h8000);
        chk("hlt pin", {15'b0, hlt1}, 16'h0001);
        for (int i = 0; i < 10; i++) do_fall("halted");
        chk("halted t_state", {13'b0, ts1}, 16'h0002);
        apply_reset("rst_after_hlt");
        chk("post hlt pin", {15'b0, hlt1}, 16'h0000);

        // LDA interrupted by an asynchronous reset at T3.
        opcode = 4'h1;
        for (int i = 0; i < 3; i++) do_fall("lda");
        #2 sys_rst = 1'b1;
        #1;
        m1 = 0; m0 = 0;
        chk("async rst t_state", {13'b0, ts1}, 16'h0000);
        chk("async rst ctrl", cw1, 16'h4004);
        check_all("async_rst");
        @(negedge sys_clk) sys_rst = 1'b0;
        do_fall("after_async");
        chk("after async t_state", {13'b0, ts1}, 16'h0001);

        // Randomized opcode/flag traffic.
        apply_reset("rst_rand");
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) opcode = 4'($urandom_range(0, 15));
            flag_c = 1'($urandom_range(0, 1));
            flag_z = 1'($urandom_range(0, 1));
            do_fall("rand");
            if (halted(m1) || halted(m0)) apply_reset("rand_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
